// File: rtl/mig_app_sequencer_if.sv
// Command/response and MIG application-interface bundle for mig_app_sequencer.
// The master modport is the sequencer; the slave modport is its environment (requester plus MIG).
interface mig_app_sequencer_if #(
   parameter int ADDR_W = 29,
   parameter int DATA_W = 128
);
   logic                  init_calib_complete;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wmask;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_wr;
   logic                  rsp_err;
   logic [DATA_W-1:0]     rsp_rdata;

   logic [ADDR_W-1:0]     app_addr;
   logic [2:0]            app_cmd;
   logic                  app_en;
   logic                  app_rdy;
   logic [DATA_W-1:0]     app_wdf_data;
   logic [DATA_W/8-1:0]   app_wdf_mask;
   logic                  app_wdf_wren;
   logic                  app_wdf_end;
   logic                  app_wdf_rdy;
   logic [DATA_W-1:0]     app_rd_data;
   logic                  app_rd_data_valid;

   modport master (
      input  init_calib_complete,
      input  req_valid, req_wr, req_addr, req_wdata, req_wmask,
      output req_ready,
      output rsp_valid, rsp_wr, rsp_err, rsp_rdata,
      input  rsp_ready,
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );

   modport slave (
      output init_calib_complete,
      output req_valid, req_wr, req_addr, req_wdata, req_wmask,
      input  req_ready,
      input  rsp_valid, rsp_wr, rsp_err, rsp_rdata,
      output rsp_ready,
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );
endinterface

// File: rtl/mig_app_sequencer.sv
// One-at-a-time command sequencer in front of the MIG 7-series application interface,
// with independent app_rdy / app_wdf_rdy handshakes, a held response port and a read timeout.
module mig_app_sequencer #(
   parameter int ADDR_W      = 29,
   parameter int DATA_W      = 128,
   parameter int TIMEOUT_W   = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                 ui_clk,
   input  logic                 ui_clk_sync_rst,
   mig_app_sequencer_if.master  bus
);

   localparam int MASK_W = DATA_W / 8;
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_RDWAIT, S_RESP} state_t;

   state_t                state_q, state_nxt;
   logic                  app_en_q, app_en_nxt;
   logic                  wren_q, wren_nxt;
   logic                  req_ready_q, req_ready_nxt;
   logic                  rsp_valid_q, rsp_valid_nxt;
   logic                  rsp_wr_q, rsp_wr_nxt;
   logic                  rsp_err_q, rsp_err_nxt;
   logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_nxt;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_nxt;

   logic                  op_wr_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [2:0]            cmd_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [MASK_W-1:0]     wmask_q;

   logic accept;
   logic cmd_done;
   logic wdf_done;
   logic timeout_hit;

   assign accept      = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
   // A handshake is complete once it has been seen (flag already low) or is seen this cycle.
   assign cmd_done    = !app_en_q || bus.app_rdy;
   assign wdf_done    = !wren_q || bus.app_wdf_rdy;
   assign timeout_hit = (cnt_q == TIMEOUT_LAST);

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         state_q     <= S_IDLE;
         app_en_q    <= 1'b0;
         wren_q      <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_nxt;
         app_en_q    <= app_en_nxt;
         wren_q      <= wren_nxt;
         req_ready_q <= req_ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_wr_q    <= rsp_wr_nxt;
         rsp_err_q   <= rsp_err_nxt;
         rsp_rdata_q <= rsp_rdata_nxt;
         cnt_q       <= cnt_nxt;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (accept) begin
         op_wr_q <= bus.req_wr;
         addr_q  <= bus.req_addr;
         cmd_q   <= bus.req_wr ? 3'b000 : 3'b001;
         wdata_q <= bus.req_wdata;
         wmask_q <= bus.req_wmask;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_nxt = S_CMD;
         S_CMD: begin
            if (op_wr_q) begin
               if (cmd_done && wdf_done) state_nxt = S_RESP;
            end else if (cmd_done) begin
               state_nxt = bus.app_rd_data_valid ? S_RESP : S_RDWAIT;
            end
         end
         S_RDWAIT: if (bus.app_rd_data_valid || timeout_hit) state_nxt = S_RESP;
         S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      app_en_nxt    = app_en_q;
      wren_nxt      = wren_q;
      rsp_valid_nxt = rsp_valid_q;
      rsp_wr_nxt    = rsp_wr_q;
      rsp_err_nxt   = rsp_err_q;
      rsp_rdata_nxt = rsp_rdata_q;
      cnt_nxt       = cnt_q;
      req_ready_nxt = (state_nxt == S_IDLE) && bus.init_calib_complete;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               app_en_nxt = 1'b1;
               wren_nxt   = bus.req_wr;
            end
         end
         S_CMD: begin
            app_en_nxt = app_en_q && !bus.app_rdy;
            wren_nxt   = wren_q && !bus.app_wdf_rdy;
            if (op_wr_q) begin
               if (cmd_done && wdf_done) begin
                  rsp_valid_nxt = 1'b1;
                  rsp_wr_nxt    = 1'b1;
                  rsp_err_nxt   = 1'b0;
                  rsp_rdata_nxt = '0;
               end
            end else if (cmd_done) begin
               // Data may already arrive alongside app_rdy; take it and skip the wait state.
               if (bus.app_rd_data_valid) begin
                  rsp_valid_nxt = 1'b1;
                  rsp_wr_nxt    = 1'b0;
                  rsp_err_nxt   = 1'b0;
                  rsp_rdata_nxt = bus.app_rd_data;
               end else begin
                  cnt_nxt = '0;
               end
            end
         end
         S_RDWAIT: begin
            cnt_nxt = cnt_q + TIMEOUT_W'(1);
            if (bus.app_rd_data_valid) begin
               rsp_valid_nxt = 1'b1;
               rsp_wr_nxt    = 1'b0;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = bus.app_rd_data;
            end else if (timeout_hit) begin
               rsp_valid_nxt = 1'b1;
               rsp_wr_nxt    = 1'b0;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) rsp_valid_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_wr       = rsp_wr_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.app_en       = app_en_q;
   assign bus.app_addr     = addr_q;
   assign bus.app_cmd      = cmd_q;
   assign bus.app_wdf_wren = wren_q;
   assign bus.app_wdf_data = wdata_q;
   assign bus.app_wdf_mask = wmask_q;
   assign bus.app_wdf_end  = 1'b1;

endmodule

// File: tb/tb_mig_app_sequencer.sv
// Self-checking bench for mig_app_sequencer: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level reference model.
module tb_mig_app_sequencer;

   localparam int ADDR_W = 29;
   localparam int DATA_W = 128;
   localparam int TOUT   = 32;

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [15:0]       wmask;
      int                rdy_dly;
      int                wdf_dly;
      int                rd_lat;
      int                rsp_dly;
      logic [DATA_W-1:0] rdata;
      bit                exp_err;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl [9];

   always #5 clk = ~clk;

   mig_app_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mig_app_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(16), .TIMEOUT_CYC(TOUT)
   ) dut (
      .ui_clk(clk),
      .ui_clk_sync_rst(rst),
      .bus(bus)
   );

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Transaction-level expectation: writes complete cleanly, reads return data unless it
   // arrives later than TOUT cycles after the command handshake.
   function automatic vec_t ref_model(input vec_t v);
      vec_t r = v;
      r.exp_err   = !v.wr && (v.rd_lat > TOUT);
      r.exp_rdata = (v.wr || r.exp_err) ? '0 : v.rdata;
      return r;
   endfunction

   // Runs one transaction from a negedge; the bench plays both requester and MIG.
   task automatic run_txn(input vec_t v, input bit drop_cal);
      int cyc = 0, acc_cyc = -1, hs_en = -1, hs_wdf = -1, rsp_cyc = -1;
      int en_cnt = 0, wr_cnt = 0, exp_lat;
      bit accepted = 0, done = 0;
      logic held_wr, held_err;
      logic [DATA_W-1:0] held_rdata;
      bus.req_valid = 1'b1;
      bus.req_wr    = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_wmask = v.wmask;
      while (!done && cyc < 300) begin
         if (!accepted) begin
            if (bus.req_ready) begin
               accepted = 1;
               acc_cyc  = cyc;
            end
         end else begin
            bus.req_valid = 1'b0;
            bus.req_wr    = 1'($urandom_range(0, 1));
            bus.req_addr  = ADDR_W'($urandom());
            bus.req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk1("req_ready_busy", bus.req_ready, 1'b0);
            if (drop_cal) bus.init_calib_complete = 1'b0;
         end
         if (accepted && cyc == acc_cyc + 1) begin
            chk1("accept_to_app_en", bus.app_en, 1'b1);
            chk1("accept_to_wren", bus.app_wdf_wren, v.wr);
         end
         if (bus.app_en) begin
            chk("app_addr", DATA_W'(bus.app_addr), DATA_W'(v.addr));
            chk("app_cmd", DATA_W'(bus.app_cmd), v.wr ? DATA_W'(0) : DATA_W'(1));
            en_cnt++;
            bus.app_rdy = (en_cnt > v.rdy_dly);
            if (bus.app_rdy) hs_en = cyc;
         end else begin
            bus.app_rdy = 1'($urandom_range(0, 1));
         end
         if (bus.app_wdf_wren) begin
            chk("wdf_data", bus.app_wdf_data, v.wdata);
            chk("wdf_mask", DATA_W'(bus.app_wdf_mask), DATA_W'(v.wmask));
            wr_cnt++;
            bus.app_wdf_rdy = (wr_cnt > v.wdf_dly);
            if (bus.app_wdf_rdy) hs_wdf = cyc;
         end else begin
            bus.app_wdf_rdy = 1'($urandom_range(0, 1));
         end
         if (!v.wr && hs_en >= 0 && cyc == hs_en + v.rd_lat) begin
            bus.app_rd_data_valid = 1'b1;
            bus.app_rd_data       = v.rdata;
         end else if (!accepted || bus.rsp_valid) begin
            bus.app_rd_data_valid = ($urandom_range(0, 2) == 0);
            bus.app_rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            bus.app_rd_data_valid = 1'b0;
            bus.app_rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (bus.rsp_valid) begin
            if (rsp_cyc < 0) begin
               rsp_cyc = cyc;
               if (v.wr) exp_lat = ((hs_en > hs_wdf) ? hs_en : hs_wdf) + 1;
               else      exp_lat = hs_en + ((v.rd_lat < TOUT) ? v.rd_lat : TOUT) + 1;
               chkn("rsp_latency", rsp_cyc, exp_lat);
               chk1("rsp_wr", bus.rsp_wr, v.wr);
               chk1("rsp_err", bus.rsp_err, v.exp_err);
               chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
               held_wr = bus.rsp_wr; held_err = bus.rsp_err; held_rdata = bus.rsp_rdata;
            end else begin
               chk("rsp_hold", {bus.rsp_rdata[DATA_W-3:0], bus.rsp_wr, bus.rsp_err},
                   {held_rdata[DATA_W-3:0], held_wr, held_err});
            end
            bus.rsp_ready = (cyc - rsp_cyc >= v.rsp_dly);
            if (bus.rsp_ready) done = 1;
         end else begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) chk1("txn_timeout", 1'b0, 1'b1);
      chkn("app_en_cycles", en_cnt, v.rdy_dly + 1);
      chkn("wren_cycles", wr_cnt, v.wr ? v.wdf_dly + 1 : 0);
      chk1("rsp_cleared", bus.rsp_valid, 1'b0);
      chk1("req_ready_after", bus.req_ready, !drop_cal);
      bus.app_rd_data_valid = 1'b0;
      bus.rsp_ready         = 1'b0;
      bus.app_rdy           = 1'b0;
      bus.app_wdf_rdy       = 1'b0;
      if (drop_cal) begin
         bus.init_calib_complete = 1'b1;
         @(negedge clk);
         chk1("calib_restored", bus.req_ready, 1'b1);
      end
   endtask

   initial begin
      vec_t rv;
      tbl[0] = '{1, 29'h100, 128'h00112233445566778899AABBCCDDEEFF, 16'h0000, 0, 0, 0, 0, '0, 0, '0};
      tbl[1] = '{1, 29'h200, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 16'h00F0, 0, 5, 0, 1, '0, 0, '0};
      tbl[2] = '{1, 29'h1FFFFFFF, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 16'hFFFF, 3, 0, 0, 0, '0, 0, '0};
      tbl[3] = '{0, 29'h300, '0, '0, 0, 0, 20, 0,
                 128'hAABBCCDD_EEFF0011_22334455_66778899, 0, 128'hAABBCCDD_EEFF0011_22334455_66778899};
      tbl[4] = '{0, 29'h304, '0, '0, 2, 0, 0, 3,
                 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
      tbl[5] = '{0, 29'h308, '0, '0, 1, 0, TOUT, 0,
                 128'h11111111_22222222_33333333_44444444, 0, 128'h11111111_22222222_33333333_44444444};
      tbl[6] = '{0, 29'h30C, '0, '0, 0, 0, TOUT + 1, 0, 128'h55555555_66666666_77777777_88888888, 1, '0};
      tbl[7] = '{0, 29'h310, '0, '0, 0, 0, 1000, 2, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 1, '0};
      tbl[8] = '{1, 29'h0, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 16'hA5A5, 2, 2, 0, 4, '0, 0, '0};

      rst = 1'b1;
      bus.init_calib_complete = 1'b0;
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = 1'b0;
      bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
      bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk1("reset_app_en", bus.app_en, 1'b0);
      chk1("reset_wren", bus.app_wdf_wren, 1'b0);
      chk1("reset_req_ready", bus.req_ready, 1'b0);
      chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("reset_rsp_err", bus.rsp_err, 1'b0);
      chk1("reset_rsp_wr", bus.rsp_wr, 1'b0);
      chk("reset_rsp_rdata", bus.rsp_rdata, '0);
      chk1("wdf_end_tied", bus.app_wdf_end, 1'b1);
      rst = 1'b0;

      // Requests are held off until calibration completes.
      bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 29'h55;
      bus.req_wdata = 128'h1; bus.req_wmask = 16'h0;
      repeat (4) begin
         @(negedge clk);
         chk1("nocal_req_ready", bus.req_ready, 1'b0);
         chk1("nocal_app_en", bus.app_en, 1'b0);
      end
      bus.init_calib_complete = 1'b1;
      @(negedge clk);
      chk1("cal_req_ready", bus.req_ready, 1'b1);
      chk1("cal_app_en_pre", bus.app_en, 1'b0);
      @(negedge clk);
      chk1("cal_accept_en", bus.app_en, 1'b1);
      chk1("cal_accept_wren", bus.app_wdf_wren, 1'b1);

      // Reset in the middle of the command phase.
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk1("midrst_app_en", bus.app_en, 1'b0);
      chk1("midrst_wren", bus.app_wdf_wren, 1'b0);
      chk1("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk1("midrst_req_ready", bus.req_ready, 1'b1);
      chk1("midrst_app_en_idle", bus.app_en, 1'b0);

      for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0);

      // Calibration loss after accept must not abort the transaction.
      run_txn(tbl[3], 1'b1);

      for (int i = 0; i < 40; i++) begin
         rv.wr      = 1'($urandom_range(0, 1));
         rv.addr    = ADDR_W'($urandom());
         rv.wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
         rv.wmask   = 16'($urandom());
         rv.rdy_dly = $urandom_range(0, 3);
         rv.wdf_dly = $urandom_range(0, 3);
         rv.rd_lat  = $urandom_range(0, TOUT + 8);
         rv.rsp_dly = $urandom_range(0, 2);
         rv.rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_txn(ref_model(rv), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
